// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluation: scans the attribute table, keeps the first
// MAX_PER_LINE hitting indices in priority order and streams them to tile fetch.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 64,
    parameter int IDX_W        = 6,
    parameter int MAX_PER_LINE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_start,
    input  logic [9:0]       line_y,
    output logic [9:0]       scan_y,
    output logic             attr_rd,
    output logic [IDX_W-1:0] attr_addr,
    input  logic             spr_en,
    input  logic             spr_hit,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
    localparam int PTR_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam logic [IDX_W:0] LAST = (IDX_W + 1)'(NUM_SPRITES);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_PER_LINE);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W:0]   ctr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] list [MAX_PER_LINE];
    logic [IDX_W-1:0] hit_addr;
    logic [9:0]       scan_y_q;
    logic             ovf;
    logic             scan_done;
    logic             sample;
    logic             full;
    logic             push;
    logic             xfer;
    logic             last;

    // ctr is one ahead of the entry whose enable/hit is on the inputs now
    assign scan_done = (state == SCAN) && (ctr == LAST);
    assign sample    = (state == SCAN) && (ctr != '0) && spr_en && spr_hit;
    assign hit_addr  = ctr[IDX_W-1:0] - 1'b1;
    assign full      = (count == MAXC);
    assign push      = sample && !full;
    assign xfer      = (state == DRAIN) && out_ready;
    assign last      = xfer && ((CNT_W'(rd_ptr) + CNT_W'(1)) == count);

    always_comb begin
        state_nx = state;
        if (line_start) begin
            state_nx = SCAN;
        end else begin
            unique case (state)
                IDLE:    state_nx = IDLE;
                SCAN: begin
                    if (scan_done)
                        state_nx = (push || count != '0) ? DRAIN : DONE;
                end
                DRAIN: begin
                    if (last)
                        state_nx = DONE;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctr      <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            ovf      <= 1'b0;
            scan_y_q <= '0;
        end else begin
            state <= state_nx;
            if (line_start) begin
                scan_y_q <= line_y;
                ctr      <= '0;
                count    <= '0;
                rd_ptr   <= '0;
                ovf      <= 1'b0;
            end else begin
                if (state == SCAN && !scan_done)
                    ctr <= ctr + 1'b1;
                if (push)
                    count <= count + 1'b1;
                if (sample && full)
                    ovf <= 1'b1;
                if (xfer)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !line_start)
            list[count[PTR_W-1:0]] <= hit_addr;
    end

    assign scan_y    = scan_y_q;
    assign busy      = (state != IDLE);
    assign attr_rd   = (state == SCAN) && (ctr != LAST);
    assign attr_addr = ctr[IDX_W-1:0];
    assign out_valid = (state == DRAIN);
    assign out_idx   = out_valid ? list[rd_ptr] : '0;
    assign done      = (state == DONE);
    assign overflow  = ovf;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: timeline model of each line checked every
// cycle, directed scenarios with literal expectations, then randomized lines.
module tb_sprite_line_scheduler;
    localparam int N    = 64;
    localparam int IW   = 6;
    localparam int MAXL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line_start = 1'b0;
    logic [9:0]    line_y = '0;
    logic [9:0]    scan_y;
    logic          attr_rd;
    logic [IW-1:0] attr_addr;
    logic          spr_en;
    logic          spr_hit;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    sprite_line_scheduler #(
        .NUM_SPRITES(N),
        .IDX_W(IW),
        .MAX_PER_LINE(MAXL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .line_start(line_start),
        .line_y(line_y),
        .scan_y(scan_y),
        .attr_rd(attr_rd),
        .attr_addr(attr_addr),
        .spr_en(spr_en),
        .spr_hit(spr_hit),
        .out_valid(out_valid),
        .out_idx(out_idx),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    // attribute RAM plus intersect result, one cycle read latency
    logic          pat_en  [N];
    logic          pat_hit [N];
    logic          rd_q = 1'b0;
    logic [IW-1:0] a_q = '0;
    always @(posedge clk) begin
        rd_q <= attr_rd;
        a_q  <= attr_addr;
    end
    assign spr_en  = rd_q & pat_en[a_q];
    assign spr_hit = rd_q & pat_hit[a_q];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // model state for the line in flight
    bit         armed = 0;
    bit         active = 0;
    bit         has9 = 0;
    int         t0 = 0;
    int         acc = 0;
    int         done_at = -1;
    int         ov_cycle = 0;
    int         rel = 0;
    logic [9:0] sy = '0;
    int         exp_list[$];

    // monitor of observed behaviour for literal checks
    int seen[$];
    int ls_cyc = 0;
    int first_rd = -1;
    int done_cyc = -1;
    int last_acc = -1;
    int done_cnt = 0;
    bit valid_seen = 0;

    logic          e_busy, e_done, e_rd, e_val, e_ov;
    logic [IW-1:0] e_addr, e_idx;
    logic [31:0]   ev, av;

    always @(negedge clk) begin
        if (armed) begin
            e_busy = 0; e_done = 0; e_rd = 0; e_val = 0;
            e_addr = '0; e_idx = '0;
            e_ov = has9 && (cyc >= ov_cycle);
            if (active) begin
                rel = cyc - t0;
                if (rel >= 1 && rel <= N + 1) begin
                    e_busy = 1;
                    if (rel <= N) begin
                        e_rd = 1;
                        e_addr = IW'(rel - 1);
                    end
                end else if (rel >= N + 2) begin
                    e_busy = 1;
                    if (acc < exp_list.size()) begin
                        e_val = 1;
                        e_idx = IW'(exp_list[acc]);
                    end
                    if (cyc == done_at) e_done = 1;
                end
            end
            ev = {5'b0, e_busy, e_done, e_rd, e_addr, e_val, e_idx, e_ov, sy};
            av = {5'b0, busy, done, attr_rd, attr_rd ? attr_addr : '0,
                  out_valid, out_valid ? out_idx : '0, overflow, scan_y};
            check("cycle", av, ev);
            if (out_valid && out_ready) begin
                seen.push_back(int'(out_idx));
                last_acc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (attr_rd && first_rd < 0) first_rd = cyc;
            if (out_valid) valid_seen = 1;
        end
        if (!rst_n) begin
            armed = 1;
            active = 0;
            has9 = 0;
            sy = '0;
        end else if (line_start) begin
            active = 1;
            t0 = cyc;
            sy = line_y;
            acc = 0;
            has9 = 0;
            exp_list.delete();
            for (int i = 0; i < N; i++) begin
                if (pat_en[i] && pat_hit[i]) begin
                    if (exp_list.size() < MAXL) exp_list.push_back(i);
                    else if (!has9) begin
                        has9 = 1;
                        ov_cycle = t0 + i + 3;
                    end
                end
            end
            done_at = (exp_list.size() == 0) ? t0 + N + 2 : -1;
            seen.delete();
            ls_cyc = cyc;
            first_rd = -1;
            done_cyc = -1;
            valid_seen = 0;
        end else if (active) begin
            if (cyc == done_at) active = 0;
            else if (cyc - t0 >= N + 2 && acc < exp_list.size() && out_ready) begin
                acc++;
                if (acc == exp_list.size()) done_at = cyc + 1;
            end
        end
        cyc++;
    end

    int rdy_mode = 0;
    bit tog = 1;

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = tog; tog = !tog; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic start_line(input logic [9:0] y);
        line_start = 1'b1;
        line_y = y;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check(nm, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < N; i++) begin
            pat_en[i] = 1'b0;
            pat_hit[i] = 1'b0;
        end
    endtask

    task automatic set_hit(input int i);
        pat_en[i] = 1'b1;
        pat_hit[i] = 1'b1;
    endtask

    initial begin
        int d0, n, s0, pct;
        clear_pat();
        rst_n = 1'b0;
        line_start = 1'b1;
        line_y = 10'd77;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_attr_rd", 32'(attr_rd), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_scan_y", 32'(scan_y), 32'd0);
        line_start = 1'b0;
        rst_n = 1'b1;
        step();

        clear_pat();
        set_hit(3); set_hit(17); set_hit(63);
        pat_en[5] = 1'b1;
        pat_hit[9] = 1'b1;
        rdy_mode = 0;
        start_line(10'd100);
        wait_done(200, "t2_done");
        check("t2_count", 32'(seen.size()), 32'd3);
        foreach (seen[i]) check("t2_idx", 32'(seen[i]), (i == 0) ? 3 : (i == 1) ? 17 : 63);
        check("t2_ovf", 32'(overflow), 32'd0);
        check("t2_first_rd", 32'(first_rd - ls_cyc), 32'd1);
        check("t2_done_lat", 32'(done_cyc - last_acc), 32'd1);
        step();

        for (int i = 0; i < N; i++) set_hit(i);
        start_line(10'd5);
        wait_done(200, "t3_done");
        check("t3_count", 32'(seen.size()), 32'd8);
        foreach (seen[i]) check("t3_idx", 32'(seen[i]), 32'(i));
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_done_lat", 32'(done_cyc - last_acc), 32'd1);
        step();

        clear_pat();
        start_line(10'd300);
        wait_done(200, "t4_done");
        check("t4_done_cyc", 32'(done_cyc - ls_cyc), 32'd66);
        check("t4_no_valid", 32'(valid_seen), 32'd0);
        check("t4_ovf", 32'(overflow), 32'd0);
        step();

        clear_pat();
        set_hit(5); set_hit(40); set_hit(62);
        rdy_mode = 1;
        tog = 1;
        start_line(10'd512);
        wait_done(300, "t5_done");
        check("t5_count", 32'(seen.size()), 32'd3);
        foreach (seen[i]) check("t5_idx", 32'(seen[i]), (i == 0) ? 5 : (i == 1) ? 40 : 62);
        step();

        clear_pat();
        set_hit(1); set_hit(2); set_hit(30); set_hit(50);
        rdy_mode = 3;
        start_line(10'd150);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("t6_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        s0 = (seen.size() > 0) ? seen[0] : -1;
        check("t6_one_acc", 32'(seen.size()), 32'd1);
        check("t6_first", 32'(s0), 32'd1);
        d0 = done_cnt;
        clear_pat();
        set_hit(7); set_hit(8);
        rdy_mode = 0;
        line_start = 1'b1;
        line_y = 10'd200;
        step();
        line_start = 1'b0;
        check("t6_valid_drop", 32'(out_valid), 32'd0);
        check("t6_scan_y", 32'(scan_y), 32'd200);
        check("t6_rescan", 32'({attr_rd, attr_addr}), 32'h40);
        wait_done(200, "t6_done");
        check("t6_one_done", 32'(done_cnt - d0), 32'd1);
        check("t6_list", 32'(seen.size()), 32'd2);
        step();

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0: pct = 0;
                1: pct = 4;
                2: pct = 12;
                3: pct = 40;
                default: pct = 100;
            endcase
            for (int i = 0; i < N; i++) begin
                pat_en[i] = ($urandom_range(0, 99) < 80);
                pat_hit[i] = ($urandom_range(0, 99) < pct);
            end
            rdy_mode = $urandom_range(0, 2);
            start_line(10'($urandom_range(0, 1023)));
            if (k == 12) begin
                repeat ($urandom_range(2, 80)) step();
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else if (k != 23 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 100)) step();
            end else begin
                wait_done(600, "rand_done");
            end
        end
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
